vga_timing_ctrl: RTL and testbench

Raster timing generator and pixel output stage for the VGA path. It runs horizontal and vertical counters and presents the active-area pixel address to the colour logic as `addr_h`/`addr_v`. It then takes back the 16-bit `rgb_data` that the colour logic returns a fixed number of cycles later. It delays `hsync`, `vsync` and data-enable by the same amount so that sync and colour leave the chip aligned, and it forces colour to black during blanking.

---
 rtl/vga_timing_ctrl_pkg.sv | 16 +
 rtl/sync_delay_line.sv | 37 +++
 rtl/vga_timing_ctrl.sv | 90 +++++++++
 tb/tb_vga_timing_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// vga_timing_ctrl_pkg: shared RGB565 black and 640x480@60 timing defaults
//   Imported by the timing block and the colour logic so both agree on the
//   active geometry. No ports.
package vga_timing_ctrl_pkg;
    localparam logic [15:0] BLACK        = 16'h0000;
    localparam int          CNT_W        = 12;
    localparam int          H_SYNC_DEF   = 96;
    localparam int          H_BACK_DEF   = 48;
    localparam int          H_ACTIVE_DEF = 640;
    localparam int          H_FRONT_DEF  = 16;
    localparam int          V_SYNC_DEF   = 2;
    localparam int          V_BACK_DEF   = 33;
    localparam int          V_ACTIVE_DEF = 480;
    localparam int          V_FRONT_DEF  = 10;
    localparam int          PIPE_DLY_DEF = 2;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage, W-bit shift register with per-bit async reset value
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : stage-0 input
//   q          : last stage (DEPTH-1)
//   tap        : bit TAP_BIT of stage TAP_STAGE, or of the raw input when TAP_STAGE < 0
module sync_delay_line #(
    parameter int           DEPTH     = 1,
    parameter int           W         = 1,
    parameter logic [W-1:0] RST_VAL   = '0,
    parameter int           TAP_STAGE = -1,
    parameter int           TAP_BIT   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         tap
);
    logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d[0] = d;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr_q <= {DEPTH{RST_VAL}};
        else        sr_q <= sr_d;

    assign q = sr_q[DEPTH-1];

    if (TAP_STAGE < 0) begin : g_tap_in
        assign tap = d[TAP_BIT];
    end else begin : g_tap_reg
        assign tap = sr_q[TAP_STAGE][TAP_BIT];
    end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster counters, active-area addressing and aligned sync/colour output
//   vga_clk, rst_n       : pixel clock, asynchronous active-low reset
//   rgb_data             : RGB565 returned by the colour logic PIPE_DLY cycles after addr_*
//   addr_h, addr_v       : active-area column/row (0 outside the active area)
//   addr_valid           : counters inside the active area
//   frame_start          : undelayed pulse at counter position (0,0)
//   vga_hs, vga_vs       : active-low syncs, delayed PIPE_DLY+1 cycles
//   vga_de, vga_rgb      : delayed data enable and blank-masked colour
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int PIPE_DLY = PIPE_DLY_DEF
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic [15:0]      rgb_data,
    output logic [CNT_W-1:0] addr_h,
    output logic [CNT_W-1:0] addr_v,
    output logic             addr_valid,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [15:0]      vga_rgb
);
    localparam logic [CNT_W-1:0] H_TOTAL = CNT_W'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] V_TOTAL = CNT_W'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SW    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SW    = CNT_W'(V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [15:0]      rgb_q, rgb_d;
    logic             h_end, hs_raw, vs_raw, de_raw, tap_de;

    always_comb begin
        h_end   = h_cnt_q == H_TOTAL - 1'b1;
        h_cnt_d = h_end ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = !h_end ? v_cnt_q : (v_cnt_q == V_TOTAL - 1'b1) ? '0 : v_cnt_q + 1'b1;
        hs_raw  = h_cnt_q >= H_SW;
        vs_raw  = v_cnt_q >= V_SW;
        de_raw  = (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
                  (v_cnt_q >= V_START) && (v_cnt_q < V_END);
        rgb_d   = tap_de ? rgb_data : BLACK;
    end

    always_ff @(posedge vga_clk or negedge rst_n)
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            rgb_q   <= BLACK;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            rgb_q   <= rgb_d;
        end

    assign addr_valid  = de_raw;
    assign addr_h      = de_raw ? h_cnt_q - H_START : '0;
    assign addr_v      = de_raw ? v_cnt_q - V_START : '0;
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign vga_rgb     = rgb_q;

    // The tap one stage before the output qualifies the colour register, so
    // the registered colour lands in the same cycle as the delayed de.
    sync_delay_line #(
        .DEPTH     (PIPE_DLY + 1),
        .W         (3),
        .RST_VAL   (3'b110),
        .TAP_STAGE (PIPE_DLY - 1),
        .TAP_BIT   (0)
    ) u_sync_dly (
        .clk   (vga_clk),
        .rst_n (rst_n),
        .d     ({hs_raw, vs_raw, de_raw}),
        .q     ({vga_hs, vga_vs, vga_de}),
        .tap   (tap_de)
    );
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of raster timing, addressing, latency and masking
module tb_vga_timing_ctrl;
    localparam int HT = 800;
    localparam int VT = 41;
    localparam int FR = HT * VT;

    logic        vga_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rgb_data = 16'h0;
    logic [11:0] addr_h, addr_v;
    logic        addr_valid, frame_start, vga_hs, vga_vs, vga_de;
    logic [15:0] vga_rgb;

    int          tests = 0, fails = 0, c = 0;
    int          first_av, first_de, vs_lo, fs_cnt;
    int          hs_lo [2];
    logic [11:0] a1, a2;

    always #5 vga_clk = ~vga_clk;

    vga_timing_ctrl #(.V_ACTIVE(4), .V_FRONT(2), .PIPE_DLY(2)) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .rgb_data    (rgb_data),
        .addr_h      (addr_h),
        .addr_v      (addr_v),
        .addr_valid  (addr_valid),
        .frame_start (frame_start),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_rgb     (vga_rgb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at c=%0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic act(input int h, input int v);
        return h >= 144 && h < 784 && v >= 35 && v < 39;
    endfunction

    task automatic chk_rst();
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_vs", 32'(vga_vs), 32'd1);
        chk("rst_de", 32'(vga_de), 32'd0);
        chk("rst_rgb", 32'(vga_rgb), 32'd0);
        chk("rst_addr_h", 32'(addr_h), 32'd0);
        chk("rst_addr_v", 32'(addr_v), 32'd0);
        chk("rst_addr_valid", 32'(addr_valid), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd1);
    endtask

    task automatic check_cycle();
        int  h, v, hp, vp;
        logic de_e;
        h = c % HT;
        v = (c / HT) % VT;
        chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
        chk("addr_valid", 32'(addr_valid), 32'(act(h, v)));
        chk("addr_h", 32'(addr_h), act(h, v) ? 32'(h - 144) : 32'd0);
        chk("addr_v", 32'(addr_v), act(h, v) ? 32'(v - 35) : 32'd0);
        if (c < 3) begin
            chk("vga_hs", 32'(vga_hs), 32'd1);
            chk("vga_vs", 32'(vga_vs), 32'd1);
            chk("vga_de", 32'(vga_de), 32'd0);
            chk("vga_rgb", 32'(vga_rgb), 32'd0);
        end else begin
            hp = (c - 3) % HT;
            vp = ((c - 3) / HT) % VT;
            de_e = act(hp, vp);
            chk("vga_hs", 32'(vga_hs), 32'(hp >= 96));
            chk("vga_vs", 32'(vga_vs), 32'(vp >= 2));
            chk("vga_de", 32'(vga_de), 32'(de_e));
            chk("vga_rgb", 32'(vga_rgb), !de_e ? 32'd0 : vp >= 37 ? 32'hFFFF : 32'(hp - 144));
        end
        if (c >= 3 && c < 3 + 2 * HT && !vga_hs) hs_lo[(c - 3) / HT]++;
        if (c >= 3 && c < FR + 3 && !vga_vs) vs_lo++;
        if (c < FR && frame_start) fs_cnt++;
        if (addr_valid && first_av < 0) first_av = c;
        if (vga_de && first_de < 0) first_de = c;
    endtask

    // Colour logic model: returns {4'b0, addr_h} two cycles later, or solid
    // white on the last two active rows to exercise blank masking.
    task automatic drive();
        rgb_data = (((c / HT) % VT) >= 37) ? 16'hFFFF : {4'b0, a2};
        a2 = a1;
        a1 = addr_h;
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
        c++;
        check_cycle();
        drive();
    endtask

    task automatic restart();
        @(posedge vga_clk);
        #1;
        rst_n = 1'b1;
        c = 0;
        a1 = '0;
        a2 = '0;
        hs_lo[0] = 0;
        hs_lo[1] = 0;
        vs_lo = 0;
        fs_cnt = 0;
        first_av = -1;
        first_de = -1;
        #1;
        check_cycle();
        drive();
    endtask

    initial begin
        repeat (3) @(posedge vga_clk);
        #1;
        chk_rst();
        restart();
        while (c < 3 + 2 * HT) step();
        chk("hs_low_line0", 32'(hs_lo[0]), 32'd96);
        chk("hs_low_line1", 32'(hs_lo[1]), 32'd96);
        while (c < 35 * HT + 144) step();
        chk("first_px_addr_h", 32'(addr_h), 32'd0);
        chk("first_px_addr_v", 32'(addr_v), 32'd0);
        chk("first_px_valid", 32'(addr_valid), 32'd1);
        while (c < 35 * HT + 783) step();
        chk("last_px_addr_h", 32'(addr_h), 32'd639);
        step();
        chk("after_last_valid", 32'(addr_valid), 32'd0);
        chk("after_last_addr_h", 32'(addr_h), 32'd0);
        while (c < FR + 3) step();
        chk("vs_low_frame", 32'(vs_lo), 32'd1600);
        chk("frame_start_count", 32'(fs_cnt), 32'd1);
        chk("first_av_cycle", 32'(first_av), 32'(35 * HT + 144));
        chk("de_latency", 32'(first_de - first_av), 32'd3);
        while (c < FR + HT + 400) step();
        chk("pre_rst_vs", 32'(vga_vs), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rst();
        repeat (2) @(posedge vga_clk);
        #1;
        chk_rst();
        restart();
        while (c < 3 + 2 * HT) step();
        chk("hs_low_line0_rst", 32'(hs_lo[0]), 32'd96);
        chk("hs_low_line1_rst", 32'(hs_lo[1]), 32'd96);
        chk("frame_start_rst", 32'(fs_cnt), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
